// File: rtl/pulse_seq_ctrl_if.sv
// pulse_seq_ctrl_if: sequencer-to-channel bus carrying pulse config, one-hot start and done return.
interface pulse_seq_ctrl_if #(
    parameter int N_CH = 4
) ();
    logic [N_CH-1:0] pl_fire;
    logic [4:0]      pl_mlt;
    logic [16:0]     pl_duration;
    logic [N_CH-1:0] pl_done;

    modport master (output pl_fire, output pl_mlt, output pl_duration, input pl_done);
    modport slave  (input pl_fire, input pl_mlt, input pl_duration, output pl_done);
endinterface

// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl: runs a repeating program table of {ch, mlt, duration, gap} steps over a bank of pulse channels.
// Optional done-wait watchdog enabled by defining SEQ_TIMEOUT_EN.
module pulse_seq_ctrl #(
    parameter int N_CH        = 4,
    parameter int N_STEPS     = 8,
    parameter int CH_W        = 2,
    parameter int GAP_W       = 16,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int AW = $clog2(N_STEPS),
    localparam int EW = CH_W + 5 + 17 + GAP_W
) (
    input  logic                clk_Seq,
    input  logic                rst_n,
    input  logic                seq_go,
    input  logic                seq_abort,
    input  logic [AW-1:0]       last_step,
    input  logic [7:0]          rep_count,
    input  logic                tbl_we,
    input  logic [AW-1:0]       tbl_addr,
    input  logic [EW-1:0]       tbl_wdata,
    pulse_seq_ctrl_if.master    pl,
    output logic                busy,
    output logic [AW-1:0]       step_idx,
    output logic                seq_done,
    output logic                err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FIRE  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_GAP   = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DRAIN = 3'd6
    } state_t;

    if (N_STEPS != (1 << AW)) begin : g_bad_steps
        $error("N_STEPS must be a power of 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        logic [N_CH-1:0] oh;
        oh = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            oh[i] = (32'(ch) == 32'(i));
        end
        return oh;
    endfunction

    function automatic logic ch_valid(input logic [CH_W-1:0] ch);
        return (32'(ch) < 32'(N_CH));
    endfunction

    logic [EW-1:0]    tbl_mem [N_STEPS];
    logic [EW-1:0]    tbl_rd_s;
    logic [CH_W-1:0]  tbl_ch_s;
    logic [4:0]       tbl_mlt_s;
    logic [16:0]      tbl_dur_s;
    logic [GAP_W-1:0] tbl_gap_s;

    state_t           state_r;
    logic [N_CH-1:0]  done_meta_r;
    logic [N_CH-1:0]  done_sync_r;
    logic [N_CH-1:0]  fire_r;
    logic [N_CH-1:0]  ch_oh_r;
    logic [4:0]       mlt_r;
    logic [16:0]      dur_r;
    logic [GAP_W-1:0] gap_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [AW-1:0]    step_idx_r;
    logic [AW-1:0]    last_r;
    logic [7:0]       rep_r;
    logic [7:0]       reps_r;
    logic [8:0]       reps_inc_s;
    logic             busy_r;
    logic             seq_done_r;
    logic             err_r;
    logic             done_hit_s;
    logic             done_any_s;
    logic             wd_expired_s;

    assign tbl_rd_s   = tbl_mem[step_idx_r];
    assign tbl_ch_s   = tbl_rd_s[EW-1 -: CH_W];
    assign tbl_mlt_s  = tbl_rd_s[GAP_W+17 +: 5];
    assign tbl_dur_s  = tbl_rd_s[GAP_W +: 17];
    assign tbl_gap_s  = tbl_rd_s[GAP_W-1:0];

    assign done_hit_s = |(done_sync_r & ch_oh_r);
    assign done_any_s = |done_sync_r;
    assign reps_inc_s = {1'b0, reps_r} + 9'd1;

    assign pl.pl_fire     = fire_r;
    assign pl.pl_mlt      = mlt_r;
    assign pl.pl_duration = dur_r;
    assign busy           = busy_r;
    assign step_idx       = step_idx_r;
    assign seq_done       = seq_done_r;
    assign err            = err_r;

    // Program table storage; writable only while the sequencer is idle, never reset.
    always_ff @(posedge clk_Seq) begin
        if (tbl_we && (state_r == ST_IDLE)) begin
            tbl_mem[tbl_addr] <= tbl_wdata;
        end
    end

    // Two-flop synchronizer for the channel done lines, which arrive from another clock domain.
    always_ff @(posedge clk_Seq or negedge rst_n) begin
        if (!rst_n) begin
            done_meta_r <= {N_CH{1'b0}};
            done_sync_r <= {N_CH{1'b0}};
        end else begin
            done_meta_r <= pl.pl_done;
            done_sync_r <= done_meta_r;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_cnt_r;

    assign wd_expired_s = (wd_cnt_r == WD_LIM);

    // Watchdog: cycles spent waiting on one step's done handshake, restarted at every LOAD.
    always_ff @(posedge clk_Seq or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if ((state_r == ST_FIRE) || (state_r == ST_CLEAR)) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= {WD_W{1'b0}};
        end
    end
`else
    assign wd_expired_s = 1'b0;
`endif

    // Sequencer FSM with all channel-facing and status outputs registered.
    always_ff @(posedge clk_Seq or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            fire_r     <= {N_CH{1'b0}};
            ch_oh_r    <= {N_CH{1'b0}};
            mlt_r      <= 5'd0;
            dur_r      <= 17'd0;
            gap_r      <= {GAP_W{1'b0}};
            gap_cnt_r  <= {GAP_W{1'b0}};
            step_idx_r <= {AW{1'b0}};
            last_r     <= {AW{1'b0}};
            rep_r      <= 8'd0;
            reps_r     <= 8'd0;
            busy_r     <= 1'b0;
            seq_done_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            seq_done_r <= 1'b0;
            if (busy_r && seq_abort && (state_r != ST_DRAIN)) begin
                fire_r  <= {N_CH{1'b0}};
                state_r <= ST_DRAIN;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (seq_go && !seq_abort) begin
                            step_idx_r <= {AW{1'b0}};
                            reps_r     <= 8'd0;
                            err_r      <= 1'b0;
                            busy_r     <= 1'b1;
                            last_r     <= last_step;
                            rep_r      <= rep_count;
                            state_r    <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        mlt_r     <= tbl_mlt_s;
                        dur_r     <= tbl_dur_s;
                        gap_r     <= tbl_gap_s;
                        ch_oh_r   <= ch_onehot(tbl_ch_s);
                        if (ch_valid(tbl_ch_s)) begin
                            state_r <= ST_FIRE;
                        end else begin
                            err_r   <= 1'b1;
                            state_r <= ST_NEXT;
                        end
                    end
                    ST_FIRE: begin
                        // Fire rises one cycle into FIRE so the config is already stable on the bus.
                        if (wd_expired_s) begin
                            err_r   <= 1'b1;
                            fire_r  <= {N_CH{1'b0}};
                            state_r <= ST_DRAIN;
                        end else if (done_hit_s) begin
                            fire_r  <= {N_CH{1'b0}};
                            state_r <= ST_CLEAR;
                        end else begin
                            fire_r  <= ch_oh_r;
                        end
                    end
                    ST_CLEAR: begin
                        if (wd_expired_s) begin
                            err_r   <= 1'b1;
                            state_r <= ST_DRAIN;
                        end else if (!done_hit_s) begin
                            gap_cnt_r <= {GAP_W{1'b0}};
                            state_r   <= (gap_r == {GAP_W{1'b0}}) ? ST_NEXT : ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt_r == (gap_r - GAP_W'(1))) begin
                            state_r <= ST_NEXT;
                        end else begin
                            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                        end
                    end
                    ST_NEXT: begin
                        if (step_idx_r != last_r) begin
                            step_idx_r <= step_idx_r + AW'(1);
                            state_r    <= ST_LOAD;
                        end else if ((rep_r != 8'd0) && (reps_inc_s == {1'b0, rep_r})) begin
                            seq_done_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            // Saturate so an endless run can never wrap into a false completion.
                            if (reps_r != 8'hFF) begin
                                reps_r <= reps_r + 8'd1;
                            end
                            step_idx_r <= {AW{1'b0}};
                            state_r    <= ST_LOAD;
                        end
                    end
                    ST_DRAIN: begin
                        if (!done_any_s) begin
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        fire_r  <= {N_CH{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// tb_pulse_seq_ctrl: scoreboard bench; stimulus queues expected fire/done events, a monitor pops and compares.
module tb_pulse_seq_ctrl;
    localparam int N_CH     = 4;
    localparam int N_STEPS  = 8;
    localparam int CH_W     = 3;
    localparam int GAP_W    = 16;
    localparam int AW       = $clog2(N_STEPS);
    localparam int EW       = CH_W + 5 + 17 + GAP_W;
    localparam int DONE_DLY = 20;

    typedef struct {
        bit is_done;
        int ch;
        int step;
        int mlt;
        int dur;
    } ev_t;

    logic          clk_Seq = 1'b0;
    logic          rst_n = 1'b0;
    logic          seq_go = 1'b0;
    logic          seq_abort = 1'b0;
    logic [AW-1:0] last_step = '0;
    logic [7:0]    rep_count = 8'd0;
    logic          tbl_we = 1'b0;
    logic [AW-1:0] tbl_addr = '0;
    logic [EW-1:0] tbl_wdata = '0;
    logic          busy;
    logic [AW-1:0] step_idx;
    logic          seq_done;
    logic          err;

    pulse_seq_ctrl_if #(.N_CH(N_CH)) pl ();

    pulse_seq_ctrl #(.N_CH(N_CH), .N_STEPS(N_STEPS), .CH_W(CH_W), .GAP_W(GAP_W)) dut (
        .clk_Seq(clk_Seq), .rst_n(rst_n), .seq_go(seq_go), .seq_abort(seq_abort),
        .last_step(last_step), .rep_count(rep_count), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_wdata(tbl_wdata), .pl(pl), .busy(busy), .step_idx(step_idx),
        .seq_done(seq_done), .err(err)
    );

    always #5 clk_Seq = ~clk_Seq;

    int  tests_run = 0;
    int  tests_failed = 0;
    ev_t exp_q[$];
    int  cyc = 0;
    int  fire_count = 0;
    int  rise_cyc = 0;
    int  fire_len = 0;
    int  done_fall_cyc = 0;
    int  done_lat = 0;
    bit  done_at_fall = 1'b0;
    bit  hold_low = 1'b0;
    int  fcnt [N_CH];

    // Channel model: done rises DONE_DLY cycles after start is seen, drops once start is released.
    always @(posedge clk_Seq) begin
        for (int c = 0; c < N_CH; c++) begin
            if (!rst_n || hold_low) begin
                pl.pl_done[c] <= 1'b0;
                fcnt[c] <= 0;
            end else if (pl.pl_fire[c]) begin
                if (fcnt[c] == DONE_DLY - 1) pl.pl_done[c] <= 1'b1;
                else fcnt[c] <= fcnt[c] + 1;
            end else begin
                pl.pl_done[c] <= 1'b0;
                fcnt[c] <= 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N_CH-1:0] v);
        for (int i = 0; i < N_CH; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic score(input bit is_done, input int ch, input int step, input int mlt, input int dur);
        ev_t e;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_event: got done=%0d ch=%0d step=%0d, expected none", is_done, ch, step);
        end else begin
            e = exp_q.pop_front();
            if (e.is_done != is_done ||
                (!is_done && (e.ch != ch || e.step != step || e.mlt != mlt || e.dur != dur))) begin
                tests_failed++;
                $display("FAIL event: got done=%0d ch=%0d step=%0d mlt=%0d dur=%0d, expected done=%0d ch=%0d step=%0d mlt=%0d dur=%0d",
                         is_done, ch, step, mlt, dur, e.is_done, e.ch, e.step, e.mlt, e.dur);
            end
        end
    endtask

    // Monitor: fire rising edges and seq_done pulses are scored against the expectation queue.
    initial begin
        logic [N_CH-1:0] prev_fire;
        bit prev_done_any;
        prev_fire = '0;
        prev_done_any = 1'b0;
        forever begin
            @(negedge clk_Seq);
            cyc++;
            if (!rst_n) begin
                prev_fire = '0;
                prev_done_any = 1'b0;
            end else begin
                if (pl.pl_fire != '0 && prev_fire == '0) begin
                    rise_cyc = cyc;
                    fire_count++;
                    score(1'b0, oh_idx(pl.pl_fire), int'(step_idx), int'(pl.pl_mlt), int'(pl.pl_duration));
                end
                if (pl.pl_fire == '0 && prev_fire != '0) begin
                    fire_len = cyc - rise_cyc;
                    done_at_fall = |pl.pl_done;
                end
                if (prev_done_any && !(|pl.pl_done)) done_fall_cyc = cyc;
                if (seq_done) begin
                    done_lat = cyc - done_fall_cyc;
                    score(1'b1, 0, 0, 0, 0);
                end
                if ($countones(pl.pl_fire) > 1) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL onehot: got fire=%b, expected at most one bit", pl.pl_fire);
                end
                prev_fire = pl.pl_fire;
                prev_done_any = |pl.pl_done;
            end
        end
    end

    task automatic push_fire(input int ch, input int step, input int mlt, input int dur);
        ev_t e;
        e.is_done = 1'b0; e.ch = ch; e.step = step; e.mlt = mlt; e.dur = dur;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        ev_t e;
        e.is_done = 1'b1; e.ch = 0; e.step = 0; e.mlt = 0; e.dur = 0;
        exp_q.push_back(e);
    endtask

    task automatic write_entry(input int addr, input int ch, input int mlt, input int dur, input int gap);
        tbl_we = 1'b1;
        tbl_addr = AW'(addr);
        tbl_wdata = {CH_W'(ch), 5'(mlt), 17'(dur), GAP_W'(gap)};
        @(negedge clk_Seq);
        tbl_we = 1'b0;
    endtask

    task automatic start(input int last, input int rep);
        seq_go = 1'b1;
        last_step = AW'(last);
        rep_count = 8'(rep);
        @(negedge clk_Seq);
        seq_go = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk_Seq);
            n++;
        end
        if (busy) check({name, "_idle_timeout"}, 1, 0);
        repeat (2) @(negedge clk_Seq);
    endtask

    task automatic wait_fires(input string name, input int target, input int limit);
        int n = 0;
        while (fire_count < target && n < limit) begin
            @(negedge clk_Seq);
            n++;
        end
        if (fire_count < target) check({name, "_fire_timeout"}, fire_count, target);
    endtask

    initial begin
        #2_000_000;
        tests_run++;
        tests_failed++;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        int lat10;
        int base;
        int n;
        repeat (3) @(negedge clk_Seq);
        check("rst_fire", int'(pl.pl_fire), 0);
        check("rst_mlt", int'(pl.pl_mlt), 0);
        check("rst_dur", int'(pl.pl_duration), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_step", int'(step_idx), 0);
        check("rst_done_err", int'({seq_done, err}), 0);
        rst_n = 1'b1;
        @(negedge clk_Seq);

        // 1: single step with a 10-cycle gap
        write_entry(0, 1, 2, 50, 10);
        push_fire(1, 0, 2, 50);
        push_done();
        start(0, 1);
        check("t1_busy", int'(busy), 1);
        wait_idle("t1", 400);
        check("t1_fire_len_ok", int'(fire_len >= DONE_DLY + 2 && fire_len <= DONE_DLY + 4), 1);
        check("t1_done_at_fall", int'(done_at_fall), 1);
        check("t1_busy_end", int'(busy), 0);
        check("t1_err", int'(err), 0);
        check("t1_queue", exp_q.size(), 0);
        lat10 = done_lat;

        // 2: three steps, two repetitions
        write_entry(0, 0, 3, 100, 2);
        write_entry(1, 1, 4, 200, 0);
        write_entry(2, 2, 5, 300, 1);
        for (int r = 0; r < 2; r++) begin
            push_fire(0, 0, 3, 100);
            push_fire(1, 1, 4, 200);
            push_fire(2, 2, 5, 300);
        end
        push_done();
        start(2, 2);
        wait_idle("t2", 1000);
        check("t2_queue", exp_q.size(), 0);
        check("t2_err", int'(err), 0);

        // 3a: endless run aborted mid-FIRE before done
        write_entry(0, 0, 6, 10, 3);
        write_entry(1, 1, 7, 20, 3);
        push_fire(0, 0, 6, 10);
        push_fire(1, 1, 7, 20);
        push_fire(0, 0, 6, 10);
        base = fire_count;
        start(1, 0);
        wait_fires("t3a", base + 3, 400);
        repeat (5) @(negedge clk_Seq);
        seq_abort = 1'b1;
        @(negedge clk_Seq);
        seq_abort = 1'b0;
        check("t3a_fire_off", int'(pl.pl_fire), 0);
        wait_idle("t3a", 100);
        check("t3a_busy", int'(busy), 0);
        check("t3a_queue", exp_q.size(), 0);

        // 3b: abort while the channel still reports done; DRAIN must wait for it
        push_fire(0, 0, 6, 10);
        base = fire_count;
        start(1, 0);
        wait_fires("t3b", base + 1, 50);
        n = 0;
        while (!pl.pl_done[0] && n < 100) begin
            @(negedge clk_Seq);
            n++;
        end
        check("t3b_done_seen", int'(pl.pl_done[0]), 1);
        repeat (2) @(negedge clk_Seq);
        seq_abort = 1'b1;
        @(negedge clk_Seq);
        seq_abort = 1'b0;
        check("t3b_fire_off", int'(pl.pl_fire), 0);
        @(negedge clk_Seq);
        check("t3b_drain_busy", int'(busy), 1);
        wait_idle("t3b", 100);
        check("t3b_busy", int'(busy), 0);
        check("t3b_queue", exp_q.size(), 0);

        // 4: invalid channel index is skipped and flags err
        write_entry(0, 0, 1, 11, 1);
        write_entry(1, 5, 1, 22, 1);
        write_entry(2, 2, 1, 33, 1);
        push_fire(0, 0, 1, 11);
        push_fire(2, 2, 1, 33);
        push_done();
        start(2, 1);
        wait_idle("t4", 400);
        check("t4_err", int'(err), 1);
        check("t4_queue", exp_q.size(), 0);

        // 5: err cleared by go, table write while busy dropped, gap-0 latency
        write_entry(0, 3, 9, 77, 0);
        push_fire(3, 0, 9, 77);
        push_done();
        start(0, 1);
        check("t5_err_clear", int'(err), 0);
        write_entry(0, 2, 1, 1, 0);
        wait_idle("t5", 400);
        check("t5_gap_delta", lat10 - done_lat, 10);
        push_fire(3, 0, 9, 77);
        push_done();
        start(0, 1);
        wait_idle("t5r", 400);
        check("t5_queue", exp_q.size(), 0);
        seq_go = 1'b1;
        seq_abort = 1'b1;
        @(negedge clk_Seq);
        seq_go = 1'b0;
        seq_abort = 1'b0;
        repeat (4) @(negedge clk_Seq);
        check("t5_go_abort_busy", int'(busy), 0);
        check("t5_go_abort_fire", int'(pl.pl_fire), 0);

        // 6: done never returns; with no watchdog fire is still held
        hold_low = 1'b1;
        write_entry(0, 1, 4, 44, 0);
        push_fire(1, 0, 4, 44);
        start(0, 1);
        repeat (10000) @(negedge clk_Seq);
        check("t6_still_fire", int'(pl.pl_fire), 2);
        check("t6_busy", int'(busy), 1);
        seq_abort = 1'b1;
        @(negedge clk_Seq);
        seq_abort = 1'b0;
        hold_low = 1'b0;
        wait_idle("t6", 100);
        check("t6_queue", exp_q.size(), 0);

        // 7: async reset mid-FIRE
        write_entry(0, 2, 8, 88, 0);
        push_fire(2, 0, 8, 88);
        base = fire_count;
        start(0, 1);
        wait_fires("t7", base + 1, 50);
        check("t7_fire_on", int'(pl.pl_fire), 4);
        #2 rst_n = 1'b0;
        #1;
        check("t7_fire", int'(pl.pl_fire), 0);
        check("t7_mlt_dur", int'(pl.pl_mlt) + int'(pl.pl_duration), 0);
        check("t7_busy", int'(busy), 0);
        check("t7_step_done_err", int'({step_idx, seq_done, err}), 0);
        exp_q.delete();
        repeat (2) @(negedge clk_Seq);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_Seq);
        check("t7_idle_after", int'(busy), 0);
        check("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
